// File: rtl/player_cmd_scheduler.sv
// Player command scheduler: turns held-key state into per-frame move and
// fire requests, tracks projectile slot occupancy and enforces a fire cooldown.
module player_cmd_scheduler #(
  parameter logic [3:0] COOLDOWN_FRAMES = 4'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] state,
  input  logic       frame_tick,
  output logic       mv_valid,
  output logic [1:0] mv_dx,
  output logic [1:0] mv_dy,
  input  logic       mv_ready,
  output logic       fire_valid,
  output logic [1:0] fire_slot,
  input  logic       fire_ready,
  input  logic [3:0] slot_free,
  output logic [3:0] slots_busy,
  output logic       cooldown_active,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, MOVE_REQ, FIRE_REQ} fsm_e;

  fsm_e       fsm_q, fsm_d;
  logic       mv_valid_q, mv_valid_d;
  logic [1:0] mv_dx_q, mv_dx_d;
  logic [1:0] mv_dy_q, mv_dy_d;
  logic       fire_valid_q, fire_valid_d;
  logic [1:0] fire_slot_q, fire_slot_d;
  logic [3:0] slots_busy_q, slots_busy_d;
  logic [3:0] cooldown_q, cooldown_d;
  logic       pending_q, pending_d;
  logic       overrun_q, overrun_d;
  logic       fire_elig_q, fire_elig_d;

  logic [1:0] samp_dx, samp_dy, free_slot;
  logic       fire_elig;

  // Opposing keys cancel; the encodings are two's-complement steps.
  always_comb begin
    samp_dx = 2'b00;
    samp_dy = 2'b00;
    if (state[3] && !state[2]) samp_dx = 2'b01;
    else if (state[2] && !state[3]) samp_dx = 2'b11;
    if (state[1] && !state[0]) samp_dy = 2'b01;
    else if (state[0] && !state[1]) samp_dy = 2'b11;
  end

  always_comb begin
    free_slot = 2'd3;
    if (!slots_busy_q[0]) free_slot = 2'd0;
    else if (!slots_busy_q[1]) free_slot = 2'd1;
    else if (!slots_busy_q[2]) free_slot = 2'd2;
  end

  assign fire_elig = state[4] && (cooldown_q == 4'd0) && !(&slots_busy_q);

  always_comb begin
    fsm_d        = fsm_q;
    mv_valid_d   = mv_valid_q;
    mv_dx_d      = mv_dx_q;
    mv_dy_d      = mv_dy_q;
    fire_valid_d = fire_valid_q;
    fire_slot_d  = fire_slot_q;
    slots_busy_d = slots_busy_q & ~slot_free;
    cooldown_d   = cooldown_q;
    pending_d    = pending_q;
    overrun_d    = 1'b0;
    fire_elig_d  = fire_elig_q;

    if (frame_tick && (cooldown_q != 4'd0)) cooldown_d = cooldown_q - 4'd1;

    // Ticks arriving while busy are remembered once; a second one is dropped.
    if (frame_tick && (fsm_q != IDLE)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (fsm_q)
      IDLE: begin
        if (frame_tick || pending_q) begin
          pending_d   = 1'b0;
          fire_elig_d = fire_elig;
          if ((samp_dx != 2'b00) || (samp_dy != 2'b00)) begin
            fsm_d      = MOVE_REQ;
            mv_valid_d = 1'b1;
            mv_dx_d    = samp_dx;
            mv_dy_d    = samp_dy;
          end else if (fire_elig) begin
            fsm_d        = FIRE_REQ;
            fire_valid_d = 1'b1;
            fire_slot_d  = free_slot;
          end
        end
      end
      MOVE_REQ: begin
        if (mv_ready) begin
          mv_valid_d = 1'b0;
          mv_dx_d    = 2'b00;
          mv_dy_d    = 2'b00;
          if (fire_elig_q) begin
            fsm_d        = FIRE_REQ;
            fire_valid_d = 1'b1;
            fire_slot_d  = free_slot;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      FIRE_REQ: begin
        if (fire_ready) begin
          fire_valid_d              = 1'b0;
          slots_busy_d[fire_slot_q] = 1'b1;
          cooldown_d                = COOLDOWN_FRAMES;
          fsm_d                     = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= IDLE;
      mv_valid_q   <= 1'b0;
      mv_dx_q      <= 2'b00;
      mv_dy_q      <= 2'b00;
      fire_valid_q <= 1'b0;
      fire_slot_q  <= 2'd0;
      slots_busy_q <= 4'd0;
      cooldown_q   <= 4'd0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      fire_elig_q  <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      mv_valid_q   <= mv_valid_d;
      mv_dx_q      <= mv_dx_d;
      mv_dy_q      <= mv_dy_d;
      fire_valid_q <= fire_valid_d;
      fire_slot_q  <= fire_slot_d;
      slots_busy_q <= slots_busy_d;
      cooldown_q   <= cooldown_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      fire_elig_q  <= fire_elig_d;
    end
  end

  assign mv_valid        = mv_valid_q;
  assign mv_dx           = mv_dx_q;
  assign mv_dy           = mv_dy_q;
  assign fire_valid      = fire_valid_q;
  assign fire_slot       = fire_slot_q;
  assign slots_busy      = slots_busy_q;
  assign cooldown_active = (cooldown_q != 4'd0);
  assign overrun         = overrun_q;

endmodule
